// File: rtl/alu_pkg.sv
// Shared types for the integer execution unit: opcode encoding, FSM states and decode helpers.
package alu_pkg;

    localparam int unsigned OpW = 4;

    typedef enum logic [OpW-1:0] {
        OpAdd    = 4'd0,
        OpSub    = 4'd1,
        OpAnd    = 4'd2,
        OpOr     = 4'd3,
        OpXor    = 4'd4,
        OpSlt    = 4'd5,
        OpSltu   = 4'd6,
        OpSll    = 4'd7,
        OpSrl    = 4'd8,
        OpSra    = 4'd9,
        OpMul    = 4'd10,
        OpMulh   = 4'd11,
        OpMulhsu = 4'd12,
        OpMulhu  = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StOut
    } exec_state_e;

    function automatic logic is_mul(input logic [OpW-1:0] op);
        return (op >= 4'(OpMul)) && (op <= 4'(OpMulhu));
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational base ALU (ADD..SRA) with zero flag; any other opcode yields 0.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [OpW-1:0]  op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int unsigned ShW = $clog2(XLEN);

    logic [ShW-1:0] shamt;
    assign shamt = b[ShW-1:0];

    always_comb begin
        result = '0;
        case (op)
            4'(OpAdd):  result = a + b;
            4'(OpSub):  result = a - b;
            4'(OpAnd):  result = a & b;
            4'(OpOr):   result = a | b;
            4'(OpXor):  result = a ^ b;
            4'(OpSlt):  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            4'(OpSltu): result = {{(XLEN-1){1'b0}}, a < b};
            4'(OpSll):  result = a << shamt;
            4'(OpSrl):  result = a >> shamt;
            4'(OpSra):  result = $unsigned($signed(a) >>> shamt);
            default:    result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// Tagged integer execution unit: registered 1-cycle ALU path plus an iterative radix-2
// shift-add multiplier, with valid/ready handshakes and flush.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned TAG_W  = 6,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned CntW = $clog2(XLEN + 1);

    exec_state_e       state_q, state_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              hi_q, hi_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              zero_q, zero_d;

    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    alu_comb #(
        .XLEN(XLEN)
    ) u_alu_comb (
        .op    (in_op),
        .a     (in_a),
        .b     (in_b),
        .result(alu_result),
        .zero  (alu_zero)
    );

    // Incoming mul decode: operate on magnitudes, remember whether to negate the product.
    logic            in_is_mul, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        in_is_mul = MUL_EN && is_mul(in_op);
        a_neg     = ((in_op == 4'(OpMulh)) || (in_op == 4'(OpMulhsu))) && in_a[XLEN-1];
        b_neg     = (in_op == 4'(OpMulh)) && in_b[XLEN-1];
        mag_a     = a_neg ? -in_a : in_a;
        mag_b     = b_neg ? -in_b : in_b;
    end

    // Accumulator holds {partial high, remaining multiplier bits}; one bit retired per cycle.
    logic [XLEN-1:0]   addend;
    logic [XLEN:0]     step_sum;
    logic [2*XLEN-1:0] acc_step, prod;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        addend   = acc_q[0] ? mcand_q : '0;
        step_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
        acc_step = {step_sum, acc_q[XLEN-1:1]};
        prod     = neg_q ? -acc_step : acc_step;
        mul_res  = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

    logic accept;

    always_comb begin
        in_ready = 1'b0;
        if (!flush) begin
            case (state_q)
                StIdle:  in_ready = 1'b1;
                StOut:   in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        tag_d   = tag_q;
        res_d   = res_q;
        zero_d  = zero_q;

        case (state_q)
            StMul: begin
                if (cnt_q != '0) begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q == CntW'(1)) begin
                    res_d   = mul_res;
                    zero_d  = (mul_res == '0);
                    state_d = StOut;
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: ;
        endcase

        // accept implies IDLE, or OUT with the current result leaving this cycle
        if (accept) begin
            tag_d = in_tag;
            if (in_is_mul) begin
                acc_d   = {{XLEN{1'b0}}, mag_b};
                mcand_d = mag_a;
                cnt_d   = CntW'(XLEN);
                neg_d   = a_neg ^ b_neg;
                hi_d    = (in_op != 4'(OpMul));
                state_d = StMul;
            end else begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                state_d = StOut;
            end
        end

        if (flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= 1'b0;
            tag_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid  = (state_q == StOut);
    assign out_result = res_q;
    assign out_zero   = zero_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results queued at issue, popped on output.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [5:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [5:0]  out_tag;

    logic        d0_in_valid;
    logic        d0_in_ready;
    logic [3:0]  d0_in_op;
    logic [31:0] d0_in_a;
    logic [31:0] d0_in_b;
    logic [5:0]  d0_in_tag;
    logic        d0_out_valid;
    logic [31:0] d0_out_result;
    logic        d0_out_zero;
    logic [5:0]  d0_out_tag;

    alu_exec_unit #(
        .XLEN  (32),
        .TAG_W (6),
        .MUL_EN(1'b1)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    alu_exec_unit #(
        .XLEN  (32),
        .TAG_W (6),
        .MUL_EN(1'b0)
    ) u_dut_nomul (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .in_valid  (d0_in_valid),
        .in_ready  (d0_in_ready),
        .in_op     (d0_in_op),
        .in_a      (d0_in_a),
        .in_b      (d0_in_b),
        .in_tag    (d0_in_tag),
        .out_valid (d0_out_valid),
        .out_ready (1'b1),
        .out_result(d0_out_result),
        .out_zero  (d0_out_zero),
        .out_tag   (d0_out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_pops = 0;
    int   stalls = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb_l;
        longint      ub;
        logic [63:0] p;
        logic [4:0]  sh;
        sa   = $signed(a);
        sb_l = $signed(b);
        ub   = longint'({32'b0, b});
        sh   = b[4:0];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return {31'b0, $signed(a) < $signed(b)};
            4'd6:  return {31'b0, a < b};
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return $signed(a) >>> sh;
            4'd10: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            4'd11: begin p = sa * sb_l; return p[63:32]; end
            4'd12: begin p = sa * ub; return p[63:32]; end
            4'd13: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: compare every transferred result against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            n_pops++;
            if (sb.size() == 0) begin
                check("out_while_sb_empty", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("result", 64'(out_result), 64'(e.res));
                check("tag", 64'(out_tag), 64'(e.tag));
                check("zero", 64'(out_zero), 64'(e.res == 32'h0));
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag, input logic [31:0] exp, input bit push);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited != 0) stalls++;
        if (!in_ready) begin
            check("issue_timeout", 64'(in_ready), 64'd1);
        end else if (push) begin
            sb.push_back('{tag: tag, res: exp});
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic mul_latency(input logic [3:0] op, input logic [5:0] tag,
                               input logic [31:0] exp);
        int   c;
        logic busy_ready;
        c          = 0;
        busy_ready = 1'b0;
        issue(op, 32'hFFFF_FFFF, 32'hFFFF_FFFF, tag, exp, 1'b1);
        while (c < 100) begin
            @(negedge clk);
            c++;
            if (out_valid) break;
            busy_ready |= in_ready;
        end
        check("mul_latency", 64'(c), 64'd33);
        check("mul_busy_in_ready", 64'(busy_ready), 64'd0);
        step();
    endtask

    task automatic quiet_window(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int          pops0;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_op       = 4'd0;
        in_a        = '0;
        in_b        = '0;
        in_tag      = '0;
        out_ready   = 1'b1;
        d0_in_valid = 1'b0;
        d0_in_op    = 4'd10;
        d0_in_a     = 32'hFFFF_FFFF;
        d0_in_b     = 32'hFFFF_FFFF;
        d0_in_tag   = 6'd7;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_zero", 64'(out_zero), 64'd1);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        step();

        // Directed ALU cases
        issue(4'd0, 32'd5, 32'd7, 6'd3, 32'd12, 1'b1);
        issue(4'd1, 32'd9, 32'd9, 6'd4, 32'd0, 1'b1);
        issue(4'd9, 32'h8000_0000, 32'd4, 6'd5, 32'hF800_0000, 1'b1);
        issue(4'd5, 32'hFFFF_FFFF, 32'd1, 6'd6, 32'd1, 1'b1);
        issue(4'd6, 32'hFFFF_FFFF, 32'd1, 6'd7, 32'd0, 1'b1);
        issue(4'd14, 32'd3, 32'd4, 6'd8, 32'd0, 1'b1);
        issue(4'd0, 32'hFFFF_FFFF, 32'd1, 6'd9, 32'd0, 1'b1);
        drain("drain_alu");
        step();

        // Multiplies: latency and corner values
        mul_latency(4'd10, 6'd10, 32'h0000_0001);
        mul_latency(4'd11, 6'd11, 32'h0000_0000);
        mul_latency(4'd13, 6'd12, 32'hFFFF_FFFE);
        mul_latency(4'd12, 6'd13, 32'hFFFF_FFFF);
        issue(4'd11, 32'h8000_0000, 32'h8000_0000, 6'd14, 32'h4000_0000, 1'b1);
        issue(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15, 32'h8000_0000, 1'b1);
        issue(4'd10, 32'd12345, 32'hFFFF_FFFE, 6'd16, 32'hFFFF_9F8E, 1'b1);
        drain("drain_mul");
        step();

        // Back-to-back ALU ops
        stalls = 0;
        pops0  = n_pops;
        for (int i = 1; i <= 8; i++) begin
            issue(4'd0, 32'(i), 32'd100, 6'(i), 32'(i + 100), 1'b1);
        end
        @(negedge clk);
        #1;
        check("b2b_pops", 64'(n_pops - pops0), 64'd8);
        check("b2b_stalls", 64'(stalls), 64'd0);
        step();

        // Output hold with out_ready low
        issue(4'd4, 32'h0F0F_0F0F, 32'hFFFF_0000, 6'd9, 32'hF0F0_0F0F, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", 64'(out_result), 64'hF0F0_0F0F);
            check("hold_tag", 64'(out_tag), 64'd9);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        step();
        out_ready = 1'b1;
        drain("drain_hold");
        step();

        // Flush ten cycles into a MUL
        issue(4'd10, 32'd7, 32'd9, 6'd20, 32'd63, 1'b0);
        repeat (9) step();
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("post_flush_in_ready", 64'(in_ready), 64'd1);
        quiet_window("flush_no_output", 40);
        step();
        issue(4'd0, 32'd40, 32'd2, 6'd21, 32'd42, 1'b1);
        drain("drain_flush");
        step();

        // Asynchronous reset mid-MUL
        issue(4'd13, 32'hFFFF_FFFF, 32'h1234_5678, 6'd22, 32'h0, 1'b0);
        repeat (5) step();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mul_out_valid", 64'(out_valid), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mul_in_ready", 64'(in_ready), 64'd1);
        quiet_window("rst_mul_no_output", 40);
        step();

        // Asynchronous reset while a result is held
        out_ready = 1'b0;
        issue(4'd3, 32'd1, 32'd2, 6'd5, 32'd3, 1'b0);
        @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_hold_valid", 64'(out_valid), 64'd0);
        check("rst_hold_result", 64'(out_result), 64'd0);
        check("rst_hold_zero", 64'(out_zero), 64'd1);
        check("rst_hold_tag", 64'(out_tag), 64'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        // MUL_EN=0 build: multiply opcode returns 0 after one cycle
        d0_in_valid = 1'b1;
        @(negedge clk);
        check("nomul_in_ready", 64'(d0_in_ready), 64'd1);
        step();
        d0_in_valid = 1'b0;
        @(negedge clk);
        check("nomul_out_valid", 64'(d0_out_valid), 64'd1);
        check("nomul_result", 64'(d0_out_result), 64'd0);
        check("nomul_zero", 64'(d0_out_zero), 64'd1);
        check("nomul_tag", 64'(d0_out_tag), 64'd7);
        step();

        // Random ops against the reference model with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 7 == 0) ra = 32'h8000_0000;
            issue(rop, ra, rb, 6'(i + 30), model(rop, ra, rb), 1'b1);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain("drain_random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
